// File: rtl/cursor_ctrl_encoder.sv
// Push-button front-end for the cursor overlay: synchronises and debounces six
// raw active-low keys, then produces masked move levels, a size-select pulse
// and a mode-select pulse, all registered in the pixel clock domain.
module cursor_ctrl_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_move_n,
  input  logic       key_size_n,
  input  logic       key_mode_n,
  output logic [3:0] move,
  output logic [3:0] size,
  output logic [1:0] mode,
  output logic [1:0] size_idx,
  output logic       mode_state
);

  localparam int NUM_KEYS = 6;
  localparam int KEY_SIZE = 4;
  localparam int KEY_MODE = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SIZE_OFF  = 2'd0,
    SIZE_L320 = 2'd1,
    SIZE_M240 = 2'd2,
    SIZE_S120 = 2'd3
  } size_state_e;

  // Key vector: bits 0-3 move (right, up, down, left), 4 size, 5 mode.
  logic [NUM_KEYS-1:0] raw_n;
  assign raw_n = {key_mode_n, key_size_n, key_move_n};

  logic [NUM_KEYS-1:0] sync1_q, sync1_d;
  logic [NUM_KEYS-1:0] sync2_q, sync2_d;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [NUM_KEYS-1:0] stable_dly_q, stable_dly_d;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];

  logic [3:0]  move_q, move_d;
  logic [3:0]  size_q, size_d;
  logic [1:0]  mode_q, mode_d;
  size_state_e size_state_q, size_state_d;
  logic        mode_state_q, mode_state_d;

  logic [NUM_KEYS-1:0] press;

  // Synchronise raw keys and debounce each one independently.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    sync1_d      = raw_n;
    sync2_d      = sync1_q;
    stable_dly_d = stable_q;
    stable_d     = stable_q;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          // Input has differed for DEBOUNCE_CYCLES samples: accept it.
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is a debounced 1->0 transition seen one cycle after it happens.
  assign press = stable_dly_q & ~stable_q;

  // Size state machine: advance one step per press and emit the new one-hot.
  always_comb begin
    size_state_d = size_state_q;
    size_d       = 4'b0000;
    if (press[KEY_SIZE]) begin
      unique case (size_state_q)
        SIZE_OFF:  begin size_state_d = SIZE_L320; size_d = 4'b0010; end
        SIZE_L320: begin size_state_d = SIZE_M240; size_d = 4'b0100; end
        SIZE_M240: begin size_state_d = SIZE_S120; size_d = 4'b1000; end
        SIZE_S120: begin size_state_d = SIZE_OFF;  size_d = 4'b0001; end
      endcase
    end
  end

  // Mode toggle pulse and masked move levels.
  always_comb begin
    mode_state_d = mode_state_q ^ press[KEY_MODE];
    mode_d       = 2'b00;
    if (press[KEY_MODE]) begin
      mode_d = mode_state_d ? 2'b10 : 2'b01;
    end

    move_d = stable_q[3:0];
    // Opposing directions cancel: release both bits of a fully pressed pair.
    if (!stable_q[1] && !stable_q[2]) begin
      move_d[1] = 1'b1;
      move_d[2] = 1'b1;
    end
    if (!stable_q[0] && !stable_q[3]) begin
      move_d[0] = 1'b1;
      move_d[3] = 1'b1;
    end
  end

  // All state registers; reset returns every key to released and drops pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '1;
      sync2_q      <= '1;
      stable_q     <= '1;
      stable_dly_q <= '1;
      // NOTE: the counter array is tiny and must restart cleanly, so it is reset like any flop.
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= '0;
      end
      move_q       <= 4'b1111;
      size_q       <= 4'b0000;
      mode_q       <= 2'b00;
      size_state_q <= SIZE_OFF;
      mode_state_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      for (int i = 0; i < NUM_KEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      move_q       <= move_d;
      size_q       <= size_d;
      mode_q       <= mode_d;
      size_state_q <= size_state_d;
      mode_state_q <= mode_state_d;
    end
  end

  assign move       = move_q;
  assign size       = size_q;
  assign mode       = mode_q;
  assign size_idx   = size_state_q;
  assign mode_state = mode_state_q;

endmodule

// File: tb/tb_cursor_ctrl_encoder.sv
// Bench for cursor_ctrl_encoder with DEBOUNCE_CYCLES=4: directed scenarios plus
// random key activity, every cycle compared with a window-based reference model.
module tb_cursor_ctrl_encoder;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_move_n;
  logic       key_size_n;
  logic       key_mode_n;
  logic [3:0] move;
  logic [3:0] size;
  logic [1:0] mode;
  logic [1:0] size_idx;
  logic       mode_state;

  cursor_ctrl_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_move_n (key_move_n),
    .key_size_n (key_size_n),
    .key_mode_n (key_mode_n),
    .move       (move),
    .size       (size),
    .mode       (mode),
    .size_idx   (size_idx),
    .mode_state (mode_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  // Reference model state. hist[k] holds the raw keys sampled k edges ago.
  logic [5:0] hist[$];
  logic [5:0] st;        // debounced levels after the latest edge
  logic [5:0] st_prev;   // debounced levels one edge earlier
  int         m_size;
  logic       m_mode;
  logic [3:0] exp_move;
  logic [3:0] exp_size;
  logic [1:0] exp_mode;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] mask_move(input logic [3:0] lv);
    logic [3:0] r;
    r = lv;
    if (lv[1] == 1'b0 && lv[2] == 1'b0) r = r | 4'b0110;
    if (lv[0] == 1'b0 && lv[3] == 1'b0) r = r | 4'b1001;
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back(6'b111111);
    st       = '1;
    st_prev  = '1;
    m_size   = 0;
    m_mode   = 1'b0;
    exp_move = 4'b1111;
    exp_size = 4'b0000;
    exp_mode = 2'b00;
  endtask

  // One clock edge of the model: outputs from earlier debounced levels, then a
  // key is accepted if each of the last D synchronised samples disagreed with it.
  task automatic model_edge(input logic [5:0] r);
    logic [5:0] press;
    logic [5:0] new_st;
    logic [5:0] s;
    bit         all_diff;
    hist.push_front(r);
    while (hist.size() > D + 2) hist.delete(hist.size() - 1);

    exp_move = mask_move(st[3:0]);
    press    = st_prev & ~st;
    exp_size = 4'b0000;
    if (press[4]) begin
      m_size   = (m_size + 1) % 4;
      exp_size = 4'(1 << m_size);
    end
    exp_mode = 2'b00;
    if (press[5]) begin
      m_mode   = ~m_mode;
      exp_mode = m_mode ? 2'b10 : 2'b01;
    end

    for (int i = 0; i < 6; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < D; j++) begin
        s = hist[2 + j];
        if (s[i] == st[i]) all_diff = 1'b0;
      end
      new_st[i] = all_diff ? ~st[i] : st[i];
    end
    st_prev = st;
    st      = new_st;
  endtask

  task automatic compare_all();
    check("move",       {4'b0, move},       {4'b0, exp_move});
    check("size",       {4'b0, size},       {4'b0, exp_size});
    check("mode",       {6'b0, mode},       {6'b0, exp_mode});
    check("size_idx",   {6'b0, size_idx},   8'(m_size));
    check("mode_state", {7'b0, mode_state}, {7'b0, m_mode});
  endtask

  // Drive keys, take one rising edge, advance the model and compare outputs.
  task automatic tick(input logic [3:0] mv, input logic sz, input logic md);
    key_move_n = mv;
    key_size_n = sz;
    key_mode_n = md;
    @(posedge clk);
    if (rst_n) model_edge({md, sz, mv});
    else       model_reset();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(4'b1111, 1'b1, 1'b1);
  endtask

  initial begin
    int         pulses;
    int         pulse_edge;
    int         falls;
    logic       prev_bit;
    logic [3:0] sz_seen  [5];
    logic [1:0] idx_seen [5];
    logic [3:0] sz_exp   [5];
    logic [1:0] idx_exp  [5];
    int         hold     [6];
    logic [5:0] rk;

    sz_exp  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    idx_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // 1. Reset values, then a quiet period with no pulses.
    phase = "reset";
    rst_n = 1'b0;
    key_move_n = 4'b1111; key_size_n = 1'b1; key_mode_n = 1'b1;
    model_reset();
    idle(3);
    check("rst_move", {4'b0, move}, 8'h0f);
    check("rst_size", {4'b0, size}, 8'h00);
    check("rst_mode", {6'b0, mode}, 8'h00);
    rst_n = 1'b1;
    idle(10);

    // 2. Clean up press: first visible at edge 7, not at edge 6.
    phase = "move_press";
    for (int e = 1; e <= 7; e++) begin
      tick(4'b1101, 1'b1, 1'b1);
      if (e == 6) check("edge6", {4'b0, move}, 8'h0f);
      if (e == 7) check("edge7", {4'b0, move}, 8'h0d);
    end
    tick(4'b1101, 1'b1, 1'b1);
    for (int e = 1; e <= 7; e++) begin
      tick(4'b1111, 1'b1, 1'b1);
      if (e == 6) check("rel_edge6", {4'b0, move}, 8'h0d);
      if (e == 7) check("rel_edge7", {4'b0, move}, 8'h0f);
    end
    idle(4);

    // 3. Bounce on right: low3 high1 low3 high1 then steady low.
    phase = "bounce";
    falls    = 0;
    prev_bit = move[0];
    for (int e = 1; e <= 20; e++) begin
      logic b;
      b = (e == 4 || e == 8) ? 1'b1 : 1'b0;
      tick({3'b111, b}, 1'b1, 1'b1);
      if (prev_bit && !move[0]) falls++;
      prev_bit = move[0];
      if (e == 14) check("bounce_e14", {7'b0, move[0]}, 8'h01);
      if (e == 15) check("bounce_e15", {7'b0, move[0]}, 8'h00);
    end
    check("bounce_falls", 8'(falls), 8'd1);
    idle(10);

    // 4. Five size presses walk the one-hot through the wrap.
    phase  = "size_cycle";
    pulses = 0;
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 16; k++) begin
        tick(4'b1111, (k < 8) ? 1'b0 : 1'b1, 1'b1);
        if (size != 4'b0000) begin
          if (pulses < 5) begin
            sz_seen[pulses]  = size;
            idx_seen[pulses] = size_idx;
          end
          pulses++;
        end
      end
    end
    check("size_pulses", 8'(pulses), 8'd5);
    for (int p = 0; p < 5; p++) begin
      check("size_val", {4'b0, sz_seen[p]}, {4'b0, sz_exp[p]});
      check("size_idx_val", {6'b0, idx_seen[p]}, {6'b0, idx_exp[p]});
    end

    // Short reset so the next scenario starts from OFF.
    phase = "reset2";
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // 5. Opposing pairs and simultaneous size/mode presses.
    phase = "opposing";
    for (int k = 0; k < 8; k++) tick(4'b1001, 1'b1, 1'b1);
    check("up_down", {4'b0, move}, 8'h0f);
    for (int k = 0; k < 8; k++) tick(4'b0001, 1'b1, 1'b1);
    check("up_down_left", {4'b0, move}, 8'h07);
    idle(10);
    phase      = "simul";
    pulse_edge = 0;
    for (int e = 1; e <= 12; e++) begin
      tick(4'b1111, 1'b0, 1'b0);
      if (size != 4'b0000 || mode != 2'b00) begin
        pulse_edge = e;
        check("simul_size", {4'b0, size}, 8'h02);
        check("simul_mode", {6'b0, mode}, 8'h02);
      end
    end
    check("simul_edge", 8'(pulse_edge), 8'd7);
    idle(10);

    // 6. Asynchronous reset while mode key is mid-debounce.
    phase = "reset_mid";
    for (int e = 1; e <= 4; e++) tick(4'b1111, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_move",  {4'b0, move},       8'h0f);
    check("async_mstat", {7'b0, mode_state}, 8'h00);
    check("async_sidx",  {6'b0, size_idx},   8'h00);
    model_reset();
    for (int e = 1; e <= 2; e++) tick(4'b1111, 1'b1, 1'b0);
    rst_n      = 1'b1;
    pulses     = 0;
    pulse_edge = 0;
    for (int e = 1; e <= 15; e++) begin
      tick(4'b1111, 1'b1, 1'b0);
      if (mode != 2'b00) begin
        pulses++;
        pulse_edge = e;
        check("mid_mode_val", {6'b0, mode}, 8'h02);
      end
    end
    check("mid_pulses", 8'(pulses), 8'd1);
    check("mid_edge",   8'(pulse_edge), 8'd7);
    idle(10);

    // 7. Random key activity with mixed short bounces and long holds.
    phase = "random";
    rk    = 6'b111111;
    for (int i = 0; i < 6; i++) hold[i] = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 6; i++) begin
        if (hold[i] == 0) begin
          rk[i]   = 1'($urandom_range(0, 1));
          hold[i] = int'($urandom_range(1, 12));
        end
        hold[i]--;
      end
      tick(rk[3:0], rk[4], rk[5]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
